// File: rtl/ocm_seq_pkg.sv
// Shared constants for the OCM frame sequencer:
// FSM encoding, HPS status codes and parameter defaults.
package ocm_seq_pkg;

    localparam int N_RESULTS_DEF      = 10;
    localparam int RES_ADDR_W_DEF     = 4;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_OVERFLOW = 2'd2;

endpackage

// File: rtl/seq_result_writer.sv
// Captures CNN result words into the result RAM, tracks the
// word count and the sticky overflow flag.
module seq_result_writer
    import ocm_seq_pkg::*;
#(
    parameter int N_RESULTS  = N_RESULTS_DEF,
    parameter int RES_ADDR_W = RES_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  active,
    input  logic                  dv,
    input  logic [7:0]            data,
    output logic                  full,
    output logic                  overflow,
    output logic [RES_ADDR_W-1:0] res_addr,
    output logic [7:0]            res_wdata,
    output logic                  res_wren,
    output logic                  res_chip,
    output logic                  res_clk_enab
);

    // One extra bit so the count can reach N_RESULTS == 2^RES_ADDR_W.
    localparam logic [RES_ADDR_W:0] FULL_CNT = (RES_ADDR_W+1)'(N_RESULTS);

    logic [RES_ADDR_W:0] result_count;
    logic                wr;

    assign full = (result_count == FULL_CNT);
    assign wr   = active && dv && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            result_count <= '0;
            overflow     <= 1'b0;
            res_addr     <= '0;
            res_wdata    <= '0;
            res_wren     <= 1'b0;
            res_chip     <= 1'b0;
            res_clk_enab <= 1'b0;
        end else begin
            res_wren     <= wr;
            res_chip     <= wr;
            res_clk_enab <= wr;
            if (wr) begin
                res_addr  <= result_count[RES_ADDR_W-1:0];
                res_wdata <= data;
            end
            if (clear) begin
                result_count <= '0;
                overflow     <= 1'b0;
            end else if (wr) begin
                result_count <= result_count + 1'b1;
            end else if (active && dv) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ocm_frame_sequencer.sv
// Frame sequencer: launches the OCM pixel streamer on an HPS command,
// collects CNN results into on-chip RAM and reports frame status.
module ocm_frame_sequencer
    import ocm_seq_pkg::*;
#(
    parameter int N_RESULTS      = N_RESULTS_DEF,
    parameter int RES_ADDR_W     = RES_ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hps_go,
    output logic                  hps_busy,
    output logic                  hps_done,
    output logic [1:0]            hps_status,
    output logic [15:0]           frame_count,
    output logic                  rd_start,
    input  logic                  rd_finish,
    input  logic                  cnn_out_dv,
    input  logic [7:0]            cnn_out_data,
    output logic [RES_ADDR_W-1:0] res_addr,
    output logic [7:0]            res_wdata,
    output logic                  res_wren,
    output logic                  res_chip,
    output logic                  res_clk_enab
);

    localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [TW-1:0] timeout_count;
    logic          full;
    logic          overflow;
    logic          launch;
    logic          active;
    logic          timed_out;
    logic          ovf_now;
    logic          to_report;

    assign launch    = (state == S_LAUNCH);
    assign active    = (state == S_STREAM) || (state == S_DRAIN);
    assign timed_out = (state == S_DRAIN) && !cnn_out_dv
                       && (timeout_count == TO_LAST);
    // A word rejected in the exit cycle must still show as overflow.
    assign ovf_now   = overflow || (active && cnn_out_dv && full);
    assign to_report = (state == S_DRAIN) && (full || timed_out);

    assign rd_start = launch || (state == S_STREAM);
    assign hps_busy = launch || active;
    assign hps_done = (state == S_REPORT);

    seq_result_writer #(
        .N_RESULTS  (N_RESULTS),
        .RES_ADDR_W (RES_ADDR_W)
    ) u_writer (
        .clk          (clk),
        .reset        (reset),
        .clear        (launch),
        .active       (active),
        .dv           (cnn_out_dv),
        .data         (cnn_out_data),
        .full         (full),
        .overflow     (overflow),
        .res_addr     (res_addr),
        .res_wdata    (res_wdata),
        .res_wren     (res_wren),
        .res_chip     (res_chip),
        .res_clk_enab (res_clk_enab)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            timeout_count <= '0;
            frame_count   <= '0;
            hps_status    <= ST_OK;
        end else begin
            case (state)
                S_IDLE:   if (hps_go && !rd_finish) state <= S_LAUNCH;
                S_LAUNCH: state <= S_STREAM;
                S_STREAM: if (rd_finish) state <= S_DRAIN;
                S_DRAIN:  if (to_report) state <= S_REPORT;
                S_REPORT: if (!hps_go) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase

            if (launch || cnn_out_dv) begin
                timeout_count <= '0;
            end else if (state == S_DRAIN) begin
                timeout_count <= timeout_count + 1'b1;
            end

            // A full frame wins over a coincident timeout.
            if (launch) begin
                hps_status <= ST_OK;
            end else if (to_report) begin
                hps_status  <= ovf_now ? ST_OVERFLOW
                             : (full ? ST_OK : ST_TIMEOUT);
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/ocm_frame_sequencer.md
OCM_FRAME_SEQUENCER -- requirements
Module: ocm_frame_sequencer

Interface
REQ-001 The block SHALL have parameter N_RESULTS, default 10, number of CNN result words per frame.
REQ-002 The block SHALL have parameter RES_ADDR_W, default 4, result RAM address width (2^RES_ADDR_W >= N_RESULTS).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum idle cycles allowed in DRAIN.
REQ-004 The block SHALL have ports as follows: clk in 1, sole clock, all logic on rising edge.
REQ-005 The block SHALL have port reset in 1, synchronous, active-high.
REQ-006 The block SHALL have port hps_go in 1, level command from HPS, starts one frame.
REQ-007 The block SHALL have ports hps_busy out 1 (frame in progress) and hps_done out 1 (frame complete, awaiting hps_go low).
REQ-008 The block SHALL have ports hps_status out 2 (0 OK, 1 TIMEOUT, 2 OVERFLOW) and frame_count out 16 (completed frames).
REQ-009 The block SHALL have ports rd_start out 1 and rd_finish in 1, the OCM pixel-streamer handshake.
REQ-010 The block SHALL have ports cnn_out_dv in 1 and cnn_out_data in 8, the CNN result stream.
REQ-011 The block SHALL have ports res_addr out RES_ADDR_W, res_wdata out 8, res_wren out 1, res_chip out 1 and res_clk_enab out 1, the result on-chip RAM write port.

Function
REQ-012 The FSM SHALL have states IDLE, LAUNCH, STREAM, DRAIN and REPORT.
REQ-013 In IDLE, hps_go=1 SHALL move the FSM to LAUNCH, but only when rd_finish=0; otherwise it stays in IDLE.
REQ-014 LAUNCH SHALL last one cycle: clear result_count, timeout_count and the overflow flag; assert rd_start; go to STREAM.
REQ-015 rd_start SHALL be 1 in LAUNCH and STREAM and 0 in all other states.
REQ-016 In STREAM, rd_finish=1 SHALL move the FSM to DRAIN.
REQ-017 In STREAM and DRAIN, cnn_out_dv=1 with result_count<N_RESULTS SHALL write; write outputs are registered and appear the next cycle: res_wren=1, res_chip=1, res_clk_enab=1, res_addr=result_count, res_wdata=cnn_out_data; result_count then increments.
REQ-018 cnn_out_dv=1 with result_count==N_RESULTS SHALL produce no write and set the sticky overflow flag.
REQ-019 The FSM SHALL leave DRAIN for REPORT when result_count==N_RESULTS.
REQ-020 timeout_count SHALL count DRAIN cycles with cnn_out_dv=0 and clear on any dv; reaching TIMEOUT_CYCLES SHALL move the FSM to REPORT.
REQ-021 hps_status SHALL be latched on entry to REPORT with priority OVERFLOW > TIMEOUT > OK, and held until the next LAUNCH.
REQ-022 frame_count SHALL increment by 1 on each REPORT entry and wrap 0xFFFF->0.
REQ-023 REPORT SHALL hold hps_done=1 and go to IDLE when hps_go=0.
REQ-024 hps_busy SHALL be 1 in LAUNCH, STREAM and DRAIN, and 0 otherwise.
REQ-025 hps_done SHALL be 1 only in REPORT.
REQ-026 Simultaneous events: rd_finish and cnn_out_dv in the same STREAM cycle SHALL capture the word and enter DRAIN.
REQ-027 Simultaneous events: the final write and a timeout in the same cycle SHALL resolve as OK.
REQ-028 hps_go deasserting during LAUNCH, STREAM or DRAIN SHALL be ignored; the frame completes.
REQ-029 result_count reaching N_RESULTS during STREAM SHALL NOT end STREAM; the FSM waits for rd_finish.

Reset
REQ-030 Reset SHALL force IDLE and zero result_count, timeout_count, the overflow flag, frame_count and hps_status.
REQ-031 Reset SHALL force rd_start, hps_busy, hps_done, res_wren, res_chip, res_clk_enab, res_addr and res_wdata to 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no REPORT and no frame_count increment; rd_start drops in the reset cycle.

Structure
REQ-033 Package ocm_seq_pkg SHALL hold the state encoding, the status codes (OK/TIMEOUT/OVERFLOW) and the parameter defaults.
REQ-034 Sub-module seq_result_writer SHALL own result_count, the overflow flag and the registered RAM write port; the FSM, timeout counter and frame counter stay in the top level.

Verification
REQ-035 Bench: hps_go=1, rd_finish 500 cycles after rd_start, then 10 dv words 0x10..0x19 -> RAM addr 0..9 = 0x10..0x19, hps_status=0, frame_count=1, hps_done=1 until hps_go=0.
REQ-036 Bench: 6 dv words, then silence -> REPORT exactly 4096 DRAIN cycles after the last dv, hps_status=1, addr 0..5 written only.
REQ-037 Bench: 11 dv words -> 10 writes, no 11th res_wren pulse, hps_status=2.
REQ-038 Bench: reset asserted in STREAM after 3 writes -> all outputs 0 next cycle, frame_count unchanged; a new hps_go runs a full OK frame with writes starting at addr 0.
REQ-039 Bench: rd_finish and dv in the same cycle, dv count completed in DRAIN -> word captured, status 0.
REQ-040 Bench: hps_go held high through REPORT -> no relaunch until hps_go falls and rises again.
